// File: rtl/video_pkg.sv
// Shared constants and types for the monochrome video filter: display modes,
// Rec.709 luma coefficient defaults and the bundled sync/blank record.
package video_pkg;

    localparam logic [1:0] MODE_COLOR = 2'b00;
    localparam logic [1:0] MODE_GREEN = 2'b01;
    localparam logic [1:0] MODE_AMBER = 2'b10;
    localparam logic [1:0] MODE_WHITE = 2'b11;

    localparam int CW_DEF = 6;

    // Coefficients are scaled by 256 and must sum to exactly 256 so that
    // full-scale white maps to full-scale luma.
    localparam int unsigned KR_DEF = 54;
    localparam int unsigned KG_DEF = 183;
    localparam int unsigned KB_DEF = 19;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
    } sync_t;

endpackage

// File: rtl/video_mono_filter_luma_calc.sv
// Two-stage luma datapath: S1 registers the three weighted products,
// S2 registers their sum truncated to the channel width.
module luma_calc
    import video_pkg::*;
#(
    parameter int          CW = CW_DEF,
    parameter int unsigned KR = KR_DEF,
    parameter int unsigned KG = KG_DEF,
    parameter int unsigned KB = KB_DEF
) (
    input  logic          clk_vga,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    output logic [CW-1:0] y
);

    // 8 fractional bits from the /256 coefficients on top of the channel width.
    localparam int PW = CW + 8;

    logic [PW-1:0] pr;
    logic [PW-1:0] pg;
    logic [PW-1:0] pb;
    logic [PW-1:0] sum;

    assign sum = pr + pg + pb;

    // NOTE: pipeline state uses non-blocking assignments so every stage
    // samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            pr <= '0;
            pg <= '0;
            pb <= '0;
            y  <= '0;
        end else if (ce_pix) begin
            pr <= PW'(KR) * PW'(r);
            pg <= PW'(KG) * PW'(g);
            pb <= PW'(KB) * PW'(b);
            y  <= sum[PW-1:8];
        end
    end

endmodule

// File: rtl/video_mono_filter.sv
// Colour/green/amber/white display filter: luma pipeline, matching sync/blank
// delay line, frame-synchronous mode latch and the output tint stage.
module video_mono_filter
    import video_pkg::*;
#(
    parameter int          CW = CW_DEF,
    parameter int unsigned KR = KR_DEF,
    parameter int unsigned KG = KG_DEF,
    parameter int unsigned KB = KB_DEF
) (
    input  logic          clk_vga,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          hblank_in,
    input  logic          vblank_in,
    input  logic [1:0]    mode_req,
    output logic [CW-1:0] r_out,
    output logic [CW-1:0] g_out,
    output logic [CW-1:0] b_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          hblank_out,
    output logic          vblank_out,
    output logic [1:0]    mode_active
);

    logic [CW-1:0] y2;
    logic [CW-1:0] r1, g1, b1, r2, g2, b2;
    logic [CW-1:0] r_nx, g_nx, b_nx;
    sync_t         sync1, sync2;
    logic          vs_d;

    luma_calc #(.CW(CW), .KR(KR), .KG(KG), .KB(KB)) u_luma (
        .clk_vga (clk_vga),
        .reset_n (reset_n),
        .ce_pix  (ce_pix),
        .r       (r_in),
        .g       (g_in),
        .b       (b_in),
        .y       (y2)
    );

    // RGB and sync/blank ride alongside the luma datapath so S3 sees them aligned with y2.
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            r1    <= '0;
            g1    <= '0;
            b1    <= '0;
            r2    <= '0;
            g2    <= '0;
            b2    <= '0;
        end else if (ce_pix) begin
            sync1 <= '{hsync: hsync_in, vsync: vsync_in, hblank: hblank_in, vblank: vblank_in};
            sync2 <= sync1;
            r1    <= r_in;
            g1    <= g_in;
            b1    <= b_in;
            r2    <= r1;
            g2    <= g1;
            b2    <= b1;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        r_nx = r2;
        g_nx = g2;
        b_nx = b2;
        case (mode_active)
            MODE_GREEN: begin
                r_nx = '0;
                g_nx = y2;
                b_nx = '0;
            end
            MODE_AMBER: begin
                r_nx = y2;
                g_nx = y2 >> 1;
                b_nx = '0;
            end
            MODE_WHITE: begin
                r_nx = y2;
                g_nx = y2;
                b_nx = y2;
            end
            default: ;
        endcase
        if (sync2.hblank || sync2.vblank) begin
            r_nx = '0;
            g_nx = '0;
            b_nx = '0;
        end
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            r_out      <= '0;
            g_out      <= '0;
            b_out      <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblank_out <= 1'b0;
            vblank_out <= 1'b0;
        end else if (ce_pix) begin
            r_out      <= r_nx;
            g_out      <= g_nx;
            b_out      <= b_nx;
            hsync_out  <= sync2.hsync;
            vsync_out  <= sync2.vsync;
            hblank_out <= sync2.hblank;
            vblank_out <= sync2.vblank;
        end
    end

    // Mode only switches on a vsync rising edge so a frame is never split between modes.
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            vs_d        <= 1'b0;
            mode_active <= MODE_COLOR;
        end else if (ce_pix) begin
            vs_d <= vsync_in;
            if (vsync_in && !vs_d) begin
                mode_active <= mode_req;
            end
        end
    end

endmodule

// File: tb/tb_video_mono_filter.sv
// Scoreboard bench for video_mono_filter: the driver queues hand-computed
// expected pixels per ce_pix pulse, the monitor checks every clock.
module tb_video_mono_filter;
    import video_pkg::*;

    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
    } exp_t;

    logic       clk_vga = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix  = 1'b0;
    logic [5:0] r_in = '0, g_in = '0, b_in = '0;
    logic       hsync_in = 1'b0, vsync_in = 1'b0, hblank_in = 1'b0, vblank_in = 1'b0;
    logic [1:0] mode_req = 2'b00;
    logic [5:0] r_out, g_out, b_out;
    logic       hsync_out, vsync_out, hblank_out, vblank_out;
    logic [1:0] mode_active;

    exp_t exp_q[$];
    exp_t last_exp = '0;
    int   n_cmp = 0;
    int   n_bad = 0;

    video_mono_filter dut (
        .clk_vga     (clk_vga),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .r_in        (r_in),
        .g_in        (g_in),
        .b_in        (b_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hblank_in   (hblank_in),
        .vblank_in   (vblank_in),
        .mode_req    (mode_req),
        .r_out       (r_out),
        .g_out       (g_out),
        .b_out       (b_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .hblank_out  (hblank_out),
        .vblank_out  (vblank_out),
        .mode_active (mode_active)
    );

    always #5 clk_vga = ~clk_vga;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One ce_pix pulse followed by one idle clock, so ce_pix is high every 2nd clock.
    task automatic pulse(input int r, input int g, input int b,
                         input bit hs, input bit vs, input bit hb, input bit vb,
                         input int er, input int eg, input int eb);
        exp_t e;
        @(negedge clk_vga);
        r_in = 6'(r); g_in = 6'(g); b_in = 6'(b);
        hsync_in = hs; vsync_in = vs; hblank_in = hb; vblank_in = vb;
        ce_pix = 1'b1;
        e = '{r: 6'(er), g: 6'(eg), b: 6'(eb), hs: hs, vs: vs, hb: hb, vb: vb};
        exp_q.push_back(e);
        @(negedge clk_vga);
        ce_pix = 1'b0;
    endtask

    task automatic black(input bit vs);
        pulse(0, 0, 0, 1'b0, vs, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // Each output corresponds to the entry queued two pulses before the current one.
    initial begin
        forever begin
            @(posedge clk_vga);
            #1;
            if (reset_n) begin
                if (ce_pix && exp_q.size() >= 3) last_exp = exp_q.pop_front();
                check("pixel", 32'({r_out, g_out, b_out, hsync_out, vsync_out, hblank_out, vblank_out}),
                      32'(last_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        check("reset_out", 32'({r_out, g_out, b_out, hsync_out, vsync_out, hblank_out, vblank_out}), 32'd0);
        check("reset_mode", 32'(mode_active), 32'(MODE_COLOR));
        repeat (2) @(negedge clk_vga);
        reset_n = 1'b1;

        // Colour pass-through, latency 3, hold between enables.
        pulse(63, 0, 0, 0, 0, 0, 0, 63, 0, 0);
        pulse(0, 63, 0, 0, 0, 0, 0, 0, 63, 0);
        pulse(10, 20, 30, 0, 0, 0, 0, 10, 20, 30);
        black(0); black(0);

        // White mode.
        mode_req = MODE_WHITE;
        black(0); black(1);
        check("mode_white", 32'(mode_active), 32'(MODE_WHITE));
        black(0);
        pulse(63, 63, 63, 0, 0, 0, 0, 63, 63, 63);
        pulse(0, 63, 0, 0, 0, 0, 0, 45, 45, 45);

        // Amber mode.
        mode_req = MODE_AMBER;
        black(0); black(1); black(0);
        check("mode_amber", 32'(mode_active), 32'(MODE_AMBER));
        pulse(63, 0, 0, 0, 0, 0, 0, 13, 6, 0);
        pulse(0, 0, 63, 0, 0, 0, 0, 4, 2, 0);

        // Mid-frame request is deferred to the vsync rise; held vsync never re-latches.
        mode_req = MODE_GREEN;
        pulse(63, 0, 0, 0, 0, 0, 0, 13, 6, 0);
        check("mode_hold", 32'(mode_active), 32'(MODE_AMBER));
        pulse(0, 63, 0, 0, 0, 0, 0, 0, 45, 0);
        pulse(63, 63, 63, 0, 1, 0, 0, 0, 63, 0);
        check("mode_green", 32'(mode_active), 32'(MODE_GREEN));
        mode_req = MODE_WHITE;
        pulse(0, 0, 63, 0, 1, 0, 0, 0, 4, 0);
        black(1);
        check("mode_no_relatch", 32'(mode_active), 32'(MODE_GREEN));
        black(0); black(0);

        // Blanking zeroes RGB; sync is delayed unmodified.
        pulse(63, 63, 63, 0, 0, 1, 0, 0, 0, 0);
        pulse(63, 63, 63, 0, 0, 0, 1, 0, 0, 0);
        pulse(63, 63, 63, 1, 0, 0, 0, 0, 63, 0);
        pulse(63, 63, 63, 1, 0, 0, 0, 0, 63, 0);
        pulse(63, 63, 63, 0, 0, 0, 0, 0, 63, 0);

        // Asynchronous reset mid-line drops in-flight pixels.
        @(posedge clk_vga);
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        last_exp = '0;
        #1;
        check("async_reset_out",
              32'({r_out, g_out, b_out, hsync_out, vsync_out, hblank_out, vblank_out}), 32'd0);
        check("async_reset_mode", 32'(mode_active), 32'(MODE_COLOR));
        @(negedge clk_vga);
        reset_n = 1'b1;
        pulse(0, 63, 0, 0, 0, 0, 0, 0, 63, 0);
        black(0); black(0); black(0);

        repeat (4) @(negedge clk_vga);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
